// File: rtl/io_intr_pkg.sv
// io_intr_pkg: shared constants and types for the io_intr_ctrl block.
//   - register offsets, decoded from io_address[4:2]
//   - width of the channel-index / VECTOR field
//   - handshake FSM state enum (IDLE, REQ, ACK)
package io_intr_pkg;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_VECTOR = 3'd2;
    localparam logic [2:0] REG_CLEAR  = 3'd3;
    localparam logic [2:0] REG_TLOAD  = 3'd4;
    localparam logic [2:0] REG_TCTRL  = 3'd5;

    // Wide enough for channel index 0..16 (16 = timer channel at NUM_CH=16).
    localparam int VEC_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/io_intr_ctrl_if.sv
// io_intr_ctrl_if: register-port bus of the interrupt controller.
//   io_cs, io_rd, io_wr : select, read strobe, write strobe
//   io_address          : byte address (controller decodes bits [4:2])
//   io_d_in             : write data
//   io_out              : registered read data (driven by the slave)
// master = CPU side, slave = controller side.
interface io_intr_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              io_cs;
    logic              io_rd;
    logic              io_wr;
    logic [31:0]       io_address;
    logic [DATA_W-1:0] io_d_in;
    logic [DATA_W-1:0] io_out;

    modport master (
        output io_cs, io_rd, io_wr, io_address, io_d_in,
        input  io_out
    );

    modport slave (
        input  io_cs, io_rd, io_wr, io_address, io_d_in,
        output io_out
    );
endinterface

// File: rtl/io_intr_timer.sv
// io_intr_timer: down-counter for the optional timer interrupt channel.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   load  : reload the counter with tload (register write)
//   en    : count enable
//   tload : reload value
//   tick  : high while enabled and the counter is 0 (one pulse per period
//           of tload+1 cycles; every cycle when tload is 0)
module io_intr_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] tload,
    output logic               tick
);
    logic [TIMER_W-1:0] count;

    assign tick = en & (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= tload;
        end else if (en) begin
            count <= (count == '0) ? tload : count - 1'b1;
        end
    end
endmodule

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: edge-triggered interrupt controller with a register port.
//   clk     : system clock (all state changes on the rising edge)
//   reset   : synchronous, active-low reset
//   bus     : io_intr_ctrl_if.slave register port (PEND, MASK, VECTOR,
//             CLEAR, TLOAD, TCTRL at io_address[4:2] = 0..5)
//   irq_src : NUM_CH rising-edge interrupt sources
//   intr    : registered interrupt request, high while the FSM is in REQ
//   inta    : interrupt acknowledge from the CPU
// Build option: define IO_INTR_TIMER_EN to add the timer channel at
// PEND/MASK bit NUM_CH (io_intr_timer); without it TLOAD/TCTRL read 0.
module io_intr_ctrl
    import io_intr_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMER_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    io_intr_ctrl_if.slave     bus,
    input  logic [NUM_CH-1:0] irq_src,
    output logic              intr,
    input  logic              inta
);
`ifdef IO_INTR_TIMER_EN
    localparam int PW = NUM_CH + 1;
`else
    localparam int PW = NUM_CH;
`endif

    logic [PW-1:0]     pend, mask, elig, set_vec, clr_vec, cur_onehot;
    logic [NUM_CH-1:0] hist, rise;
    logic [VEC_W-1:0]  vector, cur_ch, low_ch;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en, wr_en, cur_elig, latch_cur, ack_fire;
    logic [2:0]        reg_sel;
    state_e            state, state_n;

    assign rd_en      = bus.io_cs & bus.io_rd;
    assign wr_en      = bus.io_cs & bus.io_wr;
    assign reg_sel    = bus.io_address[4:2];
    assign elig       = pend & mask;
    assign cur_onehot = PW'(1) << cur_ch;
    assign cur_elig   = |(elig & cur_onehot);

`ifdef IO_INTR_TIMER_EN
    logic [TIMER_W-1:0] tload, tload_src;
    logic               tctrl_en, timer_load, timer_tick;

    // A TLOAD write reloads the counter with the value being written.
    assign timer_load = wr_en & ((reg_sel == REG_TLOAD) | (reg_sel == REG_TCTRL));
    assign tload_src  = (wr_en && reg_sel == REG_TLOAD) ? bus.io_d_in[TIMER_W-1:0] : tload;
    assign set_vec    = {timer_tick, rise};

    always_ff @(posedge clk) begin
        if (!reset) begin
            tload    <= '0;
            tctrl_en <= 1'b0;
        end else if (wr_en) begin
            if (reg_sel == REG_TLOAD) tload    <= bus.io_d_in[TIMER_W-1:0];
            if (reg_sel == REG_TCTRL) tctrl_en <= bus.io_d_in[0];
        end
    end

    io_intr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .en    (tctrl_en),
        .tload (tload_src),
        .tick  (timer_tick)
    );
`else
    assign set_vec = rise;
`endif

    // Clears from CLEAR writes and acknowledges; sets are OR-ed in after,
    // so a same-cycle set wins.
    assign clr_vec = ((wr_en && reg_sel == REG_CLEAR) ? bus.io_d_in[PW-1:0] : '0)
                   | (ack_fire ? cur_onehot : '0);

    // Lowest-index eligible channel.
    always_comb begin
        low_ch = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (elig[i]) low_ch = VEC_W'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_PEND:   rd_data[PW-1:0]    = pend;
            REG_MASK:   rd_data[PW-1:0]    = mask;
            REG_VECTOR: rd_data[VEC_W-1:0] = vector;
`ifdef IO_INTR_TIMER_EN
            REG_TLOAD:  rd_data[TIMER_W-1:0] = tload;
            REG_TCTRL:  rd_data[0]           = tctrl_en;
`endif
            default:    rd_data = '0;
        endcase
    end

    // Handshake FSM: cur_ch is latched on entry to REQ and held until the
    // request is acknowledged or withdrawn.
    always_comb begin
        state_n   = state;
        latch_cur = 1'b0;
        ack_fire  = 1'b0;
        case (state)
            IDLE: if (|elig) begin
                state_n   = REQ;
                latch_cur = 1'b1;
            end
            REQ: begin
                if (!cur_elig) begin
                    state_n = IDLE;
                end else if (inta) begin
                    state_n  = ACK;
                    ack_fire = 1'b1;
                end
            end
            ACK:     if (!inta) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            intr       <= 1'b0;
            cur_ch     <= '0;
            vector     <= '0;
            pend       <= '0;
            mask       <= '0;
            rise       <= '0;
            // A source already high during reset must not look like an edge.
            hist       <= irq_src;
            bus.io_out <= '0;
        end else begin
            state <= state_n;
            intr  <= (state_n == REQ);
            if (latch_cur) cur_ch <= low_ch;
            if (ack_fire)  vector <= cur_ch;
            pend <= (pend & ~clr_vec) | set_vec;
            if (wr_en && reg_sel == REG_MASK) mask <= bus.io_d_in[PW-1:0];
            hist <= irq_src;
            // Edge captured here lands in PEND on the following edge.
            rise <= irq_src & ~hist;
            bus.io_out <= rd_en ? rd_data : '0;
        end
    end
endmodule

// File: tb/tb_io_intr_ctrl.sv
// Testbench for io_intr_ctrl (default build, timer channel absent).
// A reference model predicts io_out and intr after every rising edge; the
// driver pushes each prediction into a queue and an independent monitor
// pops and compares one entry per cycle.
module tb_io_intr_ctrl;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMER_W = 16;

    typedef struct {
        logic [DATA_W-1:0] out;
        logic              intr;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH-1:0] irq_src = '0;
    logic              intr;
    logic              inta = 1'b0;

    io_intr_ctrl_if #(.DATA_W(DATA_W)) bus ();

    io_intr_ctrl #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .TIMER_W (TIMER_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_src (irq_src),
        .intr    (intr),
        .inta    (inta)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    // Reference model state. m_phase: 0 = no request outstanding,
    // 1 = requesting channel m_cur, 2 = acknowledged, waiting for inta low.
    logic [NUM_CH-1:0] m_pend, m_mask, m_prev, m_fresh;
    int                m_vec, m_cur, m_phase;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        logic [DATA_W-1:0] nout;
        logic [NUM_CH-1:0] clr;
        bit                rd, wr;
        int                a;
        exp_t              e;
        nout = '0;
        if (!reset) begin
            m_pend  = '0;
            m_mask  = '0;
            m_vec   = 0;
            m_cur   = 0;
            m_phase = 0;
            m_fresh = '0;
            m_prev  = irq_src;
        end else begin
            rd = bus.io_cs && bus.io_rd;
            wr = bus.io_cs && bus.io_wr;
            a  = int'(bus.io_address[4:2]);
            if (rd) begin
                if (a == 0)      nout = DATA_W'(m_pend);
                else if (a == 1) nout = DATA_W'(m_mask);
                else if (a == 2) nout = DATA_W'(m_vec);
            end
            clr = '0;
            if (wr && a == 3) clr = bus.io_d_in[NUM_CH-1:0];
            if (m_phase == 0) begin
                if ((m_pend & m_mask) != '0) begin
                    for (int i = NUM_CH - 1; i >= 0; i--)
                        if (m_pend[i] && m_mask[i]) m_cur = i;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!(m_pend[m_cur] && m_mask[m_cur])) begin
                    m_phase = 0;
                end else if (inta) begin
                    clr[m_cur] = 1'b1;
                    m_vec      = m_cur;
                    m_phase    = 2;
                end
            end else if (!inta) begin
                m_phase = 0;
            end
            m_pend = (m_pend & ~clr) | m_fresh;
            if (wr && a == 1) m_mask = bus.io_d_in[NUM_CH-1:0];
            m_fresh = irq_src & ~m_prev;
            m_prev  = irq_src;
        end
        e.out  = nout;
        e.intr = (m_phase == 1);
        exp_q.push_back(e);
    endtask

    // Inputs are applied at the falling edge; the model is stepped for the
    // rising edge that follows.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.io_cs = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
    endtask

    task automatic set_addr(input int a);
        logic [31:0] ad;
        ad = $urandom();
        ad[4:2] = 3'(a);
        bus.io_address = ad;
    endtask

    task automatic wr_reg(input int a, input logic [DATA_W-1:0] d);
        bus.io_cs = 1'b1; bus.io_wr = 1'b1; bus.io_rd = 1'b0;
        set_addr(a);
        bus.io_d_in = d;
        step();
        bus_idle();
    endtask

    task automatic rd_reg(input int a);
        bus.io_cs = 1'b1; bus.io_rd = 1'b1; bus.io_wr = 1'b0;
        set_addr(a);
        step();
        bus_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_irq(input logic [NUM_CH-1:0] m);
        irq_src = irq_src | m;
        step();
        irq_src = irq_src & ~m;
    endtask

    // Bounded wait for the model to reach the requesting phase.
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (m_phase != 1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (m_phase != 1) begin
            fails++;
            $display("FAIL %s: no request after %0d cycles, expected one", name, n);
        end
        step();
    endtask

    task automatic ack();
        inta = 1'b1;
        step();
        inta = 1'b0;
        step();
    endtask

    // Monitor: one comparison pair per rising edge once predictions exist.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("io_out", bus.io_out, e.out);
                check("intr", DATA_W'(intr), DATA_W'(e.intr));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        bus.io_address = '0;
        bus.io_d_in    = '0;
        @(negedge clk);

        // Reset, then basic request / acknowledge on channel 2.
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        rd_reg(0);
        wr_reg(1, 32'hF);
        pulse_irq(4'b0100);
        idle(2);
        rd_reg(0);
        wait_req("req_ch2");
        ack();
        rd_reg(2);
        rd_reg(0);

        // Two channels together: lowest index served first.
        pulse_irq(4'b1010);
        wait_req("req_ch1");
        ack();
        rd_reg(2);
        wait_req("req_ch3");
        ack();
        rd_reg(2);
        rd_reg(0);

        // Masked pending, then enable, then withdraw via CLEAR.
        wr_reg(1, 32'h0);
        pulse_irq(4'b0001);
        idle(3);
        rd_reg(0);
        wr_reg(1, 32'h1);
        idle(3);
        wr_reg(3, 32'h1);
        idle(3);
        rd_reg(2);
        rd_reg(0);

        // New edge on channel 2 together with its acknowledge.
        wr_reg(1, 32'hF);
        pulse_irq(4'b0100);
        wait_req("req_ch2_a");
        inta = 1'b1;
        irq_src = 4'b0100;
        step();
        inta = 1'b0;
        irq_src = 4'b0000;
        step();
        rd_reg(0);
        wait_req("req_ch2_b");
        ack();
        rd_reg(2);

        // Reset during a request; later inta ignored.
        pulse_irq(4'b1000);
        wait_req("req_ch3_rst");
        reset = 1'b0;
        step();
        reset = 1'b1;
        inta = 1'b1;
        step();
        inta = 1'b0;
        step();
        rd_reg(0);
        rd_reg(1);

        // Source held high across reset release is not an edge.
        irq_src = 4'b0101;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(3);
        rd_reg(0);
        wr_reg(1, 32'hF);
        idle(3);
        irq_src = 4'b0000;
        idle(2);

        // Read-and-write in one access returns the old value; unused slots.
        bus.io_cs = 1'b1; bus.io_rd = 1'b1; bus.io_wr = 1'b1;
        set_addr(1);
        bus.io_d_in = 32'h5;
        step();
        bus_idle();
        rd_reg(1);
        for (int a = 3; a < 8; a++) begin
            wr_reg(a, $urandom());
            rd_reg(a);
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) irq_src = NUM_CH'($urandom());
            inta = (m_phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            bus.io_cs   = ($urandom_range(0, 2) != 0);
            bus.io_rd   = 1'($urandom());
            bus.io_wr   = ($urandom_range(0, 3) == 0);
            set_addr($urandom_range(0, 7));
            bus.io_d_in = $urandom();
            step();
        end
        reset = 1'b1;
        inta  = 1'b0;
        bus_idle();
        idle(3);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
